step_sequencer: RTL and testbench
=================================

# step_sequencer

Instruction sequencer directly upstream of the processor control unit. It holds the instruction register and the 2-bit step counter that the control unit decodes. It advances through fetch and execute steps for each instruction and returns to fetch after the opcode-specific last step. It also parks the core when a halt or undefined opcode is fetched.

## Interface

Parameters:
- DATA_W, 16, width of the DIN bus carrying instruction words
- IR_W, 10, instruction width; opcode = [9:6], rx = [5:3], ry = [2:0]
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; high allows instructions to start
- din  in  DATA_W  instruction word source; IR captures din[IR_W-1:0]
- ir_write  in  1  IR load enable from the control unit; honoured only in FETCH
- instruction  out  IR_W  registered instruction register, fed to the control unit
- counter  out  2  registered step counter, fed to the control unit
- busy  out  1  high in FETCH or EXEC
- halted  out  1  high in HALT
- retire  out  1  one-cycle pulse on the last execute step of an instruction
- retired_count  out  CNT_W  number of completed instructions, wraps

## Operation

- States: IDLE, FETCH, EXEC, HALT.
- Reset values: state IDLE, counter 0, instruction 0, busy 0, halted 0, retire 0, retired_count 0.
- IDLE: counter = 0. If run = 1, go to FETCH on the next edge.
- FETCH: counter = 0. If ir_write = 1, IR <= din[IR_W-1:0] at the end of the cycle.
  - If the newly loaded opcode is 1011 or 1100–1111, go to HALT.
  - Otherwise go to EXEC with counter = 1.
  - If ir_write = 0, IR holds its value and the sequencer still goes to EXEC using the held opcode.
- Last step, decoded from IR opcode:
  - 0000 mv, 0001 mvi, 0110 mvnz → 1
  - 0100 ld, 0101 st → 2
  - 0010, 0011, 0111, 1000, 1001, 1010 (ALU ops) → 3
- EXEC:
  - If counter ≠ last, counter increments.
  - If counter = last: assert retire, retired_count += 1 (mod 2^CNT_W), counter returns to 0.
  - Next state is FETCH if run = 1, else IDLE.
- run only gates the start of an instruction. Deasserting run mid-instruction never truncates it.
- HALT: counter = 0, IR frozen, halted = 1, busy = 0. Exit only via reset_n.
- The counter never reaches 3 for non-ALU opcodes and never wraps from 3 to anything except 0.

## Timing

- All outputs are registered. No combinational path from inputs to outputs.
- IR is visible to the control unit from the first EXEC cycle (counter = 1).
- Instruction latency, FETCH through last step: mv/mvi/mvnz 2 cycles, ld/st 3 cycles, ALU 4 cycles.
- Back-to-back instructions with run held high: FETCH of the next instruction directly follows the last step of the previous one, with no bubble.
- retire is high exactly during the last-step cycle; retired_count updates on the edge ending that cycle.
- reset_n asserted at any point, including mid-EXEC or in HALT: all state returns to reset values immediately (asynchronously). The first FETCH occurs no earlier than the second edge after release with run = 1.
- Simultaneous run fall and last step: the instruction retires and the sequencer goes to IDLE on the same edge.

## Structure

- Shared package holds:
  - opcode constants (OP_MV … OP_SRL, OP_HALT = 4'b1011)
  - the state enum
  - a last_step(opcode) function, so the control unit and sequencer agree
- One natural sub-module: `instr_reg`, an IR_W-bit load-enabled register with asynchronous clear.
- The FSM and counters stay in the top level.

## Test plan

- Reset, run = 1, din = 10'b0001_001_000 (mvi r1), ir_write in FETCH → counter 0,1,0; retire on the counter = 1 cycle; retired_count = 1.
- ALU add, din = 10'b0010_000_001 → counter 0,1,2,3,0; retire only at counter = 3; instruction stable across steps 1–3.
- ld, then st, back-to-back with run high → counter 0,1,2,0,1,2,0 with no idle cycle; retired_count = 2.
- run dropped at counter = 1 of an ALU op → steps 2 and 3 still execute, then IDLE with counter 0 and busy 0.
- Fetch 10'b1011_000_000 → HALT next edge, halted = 1; run toggling has no effect; a reset_n pulse returns to IDLE, halted = 0.
- reset_n asserted mid-EXEC at counter = 2 of st → counter, instruction and retired_count read 0 before the next clock edge.

Source files
------------

// File: rtl/step_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// step_sequencer_pkg
// Shared definitions for the instruction sequencer and the control unit that
// decodes its outputs: opcode constants, sequencer state encoding, and the
// opcode-to-last-step mapping. Both sides call last_step() so they always
// agree on how many execute steps an instruction takes.
// -----------------------------------------------------------------------------
package step_sequencer_pkg;

  localparam int OPCODE_W = 4;
  localparam int STEP_W   = 2;

  // Opcode map (instruction bits [IR_W-1 -: 4])
  localparam logic [OPCODE_W-1:0] OP_MV   = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_MVI  = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_LD   = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_ST   = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_MVNZ = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'b0111;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 4'b1001;
  localparam logic [OPCODE_W-1:0] OP_SRL  = 4'b1010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // Final execute step for each opcode. Parking opcodes (halt and the
  // undefined 11xx range) never execute, so they map to 0.
  function automatic logic [STEP_W-1:0] last_step(input logic [OPCODE_W-1:0] op);
    logic [STEP_W-1:0] step;
    case (op)
      OP_MV, OP_MVI, OP_MVNZ:                          step = 2'd1;
      OP_LD, OP_ST:                                    step = 2'd2;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRL:   step = 2'd3;
      default:                                         step = 2'd0;
    endcase
    return step;
  endfunction

  // Opcodes that park the core: explicit halt plus everything from 1100 up.
  function automatic logic is_park(input logic [OPCODE_W-1:0] op);
    return (op == OP_HALT) || (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// -----------------------------------------------------------------------------
// step_sequencer_if
// Bundle between the control unit (master) and the step sequencer (slave).
//   run           master->slave  level, allows a new instruction to start
//   din           master->slave  instruction word source
//   ir_write      master->slave  IR load enable, honoured in FETCH only
//   instruction   slave->master  registered instruction register
//   counter       slave->master  registered 2-bit step counter
//   busy          slave->master  high in FETCH or EXEC
//   halted        slave->master  high once parked in HALT
//   retire        slave->master  one-cycle pulse on an instruction's last step
//   retired_count slave->master  wrapping count of completed instructions
// -----------------------------------------------------------------------------
interface step_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int IR_W   = 10,
  parameter int CNT_W  = 16
);

  logic              run;
  logic [DATA_W-1:0] din;
  logic              ir_write;
  logic [IR_W-1:0]   instruction;
  logic [1:0]        counter;
  logic              busy;
  logic              halted;
  logic              retire;
  logic [CNT_W-1:0]  retired_count;

  modport master (
    output run, din, ir_write,
    input  instruction, counter, busy, halted, retire, retired_count
  );

  modport slave (
    input  run, din, ir_write,
    output instruction, counter, busy, halted, retire, retired_count
  );

endinterface

// File: rtl/step_sequencer_instr_reg.sv
// -----------------------------------------------------------------------------
// instr_reg
// Load-enabled instruction register with asynchronous active-low clear.
//   clock    in   system clock
//   reset_n  in   async active-low clear
//   load_i   in   capture d_i on the next rising edge
//   d_i      in   W-bit instruction word
//   q_o      out  registered instruction
// -----------------------------------------------------------------------------
module instr_reg #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] ir_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_q <= '0;
    end else if (load_i) begin
      ir_q <= d_i;
    end
  end

  assign q_o = ir_q;

endmodule

// File: rtl/step_sequencer.sv
// -----------------------------------------------------------------------------
// step_sequencer
// Instruction sequencer feeding the control unit: holds the IR and the 2-bit
// step counter, walks FETCH -> EXEC steps -> FETCH/IDLE, and parks in HALT
// when a halt or undefined opcode is fetched.
//   clock    in   system clock, rising edge
//   reset_n  in   async active-low reset
//   bus      slave modport of step_sequencer_if (see interface header)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for run; counter held at 0
// FETCH | counter 0; IR optionally loaded from din
// EXEC  | counter 1..last_step(opcode); retire on the last step
// HALT  | parked after a halt/undefined opcode; left only via reset_n
// -----------------------------------------------------------------------------
import step_sequencer_pkg::*;

module step_sequencer #(
  parameter int DATA_W = 16,
  parameter int IR_W   = 10,
  parameter int CNT_W  = 16
) (
  input logic              clock,
  input logic              reset_n,
  step_sequencer_if.slave  bus
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                retire_q, retire_d;
  logic [CNT_W-1:0]    rcnt_q, rcnt_d;

  logic                ir_load;
  logic [IR_W-1:0]     ir_q;
  logic [IR_W-1:0]     ir_next;
  logic [OPCODE_W-1:0] op_q;
  logic [OPCODE_W-1:0] op_next;

  // Upper din bits beyond the instruction width are intentionally ignored.
  logic unused_din;
  assign unused_din = ^bus.din;

  assign ir_load = (state_q == ST_FETCH) && bus.ir_write;
  // ir_next is what the IR will hold after this edge; decoding it lets
  // retire/halted be registered yet line up with the cycle they describe.
  assign ir_next = ir_load ? bus.din[IR_W-1:0] : ir_q;
  assign op_q    = ir_q[IR_W-1 -: OPCODE_W];
  assign op_next = ir_next[IR_W-1 -: OPCODE_W];

  instr_reg #(.W(IR_W)) u_instr_reg (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (ir_load),
    .d_i     (bus.din[IR_W-1:0]),
    .q_o     (ir_q)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      retire_q <= 1'b0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      retire_q <= retire_d;
      rcnt_q   <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // retire_q is high exactly during the last-step cycle, so the count
    // bumps on the edge that ends it.
    rcnt_d  = retire_q ? rcnt_q + CNT_W'(1) : rcnt_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (is_park(op_next)) begin
          state_d = ST_HALT;
          cnt_d   = '0;
        end else begin
          state_d = ST_EXEC;
          cnt_d   = 2'd1;
        end
      end
      ST_EXEC: begin
        // run is only consulted at the last step, so dropping it mid-
        // instruction never truncates the instruction.
        if (cnt_q == last_step(op_q)) begin
          cnt_d   = '0;
          state_d = bus.run ? ST_FETCH : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_HALT: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d   = (state_d == ST_FETCH) || (state_d == ST_EXEC);
    halted_d = (state_d == ST_HALT);
    retire_d = (state_d == ST_EXEC) && (cnt_d == last_step(op_next));
  end

  assign bus.instruction   = ir_q;
  assign bus.counter       = cnt_q;
  assign bus.busy          = busy_q;
  assign bus.halted        = halted_q;
  assign bus.retire        = retire_q;
  assign bus.retired_count = rcnt_q;

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

  typedef struct {
    logic        run;
    logic        irw;
    logic [15:0] din;
    logic [1:0]  cnt;
    logic [9:0]  instr;
    logic        busy;
    logic        halted;
    logic        retire;
    logic [15:0] rcnt;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  step_sequencer_if #(.DATA_W(16), .IR_W(10), .CNT_W(16)) bus ();

  step_sequencer #(.DATA_W(16), .IR_W(10), .CNT_W(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  vec_t vecs[29];

  function automatic vec_t mk(input logic run, input logic irw, input logic [15:0] din,
                              input logic [1:0] cnt, input logic [9:0] instr,
                              input logic busy, input logic halted, input logic retire,
                              input logic [15:0] rcnt);
    vec_t v;
    v.run = run; v.irw = irw; v.din = din; v.cnt = cnt; v.instr = instr;
    v.busy = busy; v.halted = halted; v.retire = retire; v.rcnt = rcnt;
    return v;
  endfunction

  task automatic check_now(input string tag, input vec_t e);
    n_vec++;
    if (bus.counter !== e.cnt) begin
      n_err++;
      $display("FAIL %s counter: got %0d expected %0d", tag, bus.counter, e.cnt);
    end
    if (bus.instruction !== e.instr) begin
      n_err++;
      $display("FAIL %s instruction: got %h expected %h", tag, bus.instruction, e.instr);
    end
    if (bus.busy !== e.busy) begin
      n_err++;
      $display("FAIL %s busy: got %b expected %b", tag, bus.busy, e.busy);
    end
    if (bus.halted !== e.halted) begin
      n_err++;
      $display("FAIL %s halted: got %b expected %b", tag, bus.halted, e.halted);
    end
    if (bus.retire !== e.retire) begin
      n_err++;
      $display("FAIL %s retire: got %b expected %b", tag, bus.retire, e.retire);
    end
    if (bus.retired_count !== e.rcnt) begin
      n_err++;
      $display("FAIL %s retired_count: got %0d expected %0d", tag, bus.retired_count, e.rcnt);
    end
  endtask

  // Drive inputs for one cycle, then check outputs 1 time unit after the edge.
  task automatic run_vec(input string tag, input vec_t v);
    bus.run      = v.run;
    bus.ir_write = v.irw;
    bus.din      = v.din;
    @(posedge clock);
    #1;
    check_now(tag, v);
  endtask

  task automatic pulse_reset_and_check(input string tag);
    reset_n = 1'b0;
    #1;
    check_now(tag, mk(0, 0, 16'h0, 2'd0, 10'h000, 0, 0, 0, 16'd0));
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    //                run irw din       cnt instr   busy hlt ret rcnt
    vecs[0]  = mk(1, 0, 16'h0000, 0, 10'h000, 1, 0, 0, 0);  // IDLE -> FETCH
    vecs[1]  = mk(1, 1, 16'hFC48, 1, 10'h048, 1, 0, 1, 0);  // mvi, upper din ignored
    vecs[2]  = mk(1, 0, 16'h0000, 0, 10'h048, 1, 0, 0, 1);
    vecs[3]  = mk(1, 1, 16'h0081, 1, 10'h081, 1, 0, 0, 1);  // add
    vecs[4]  = mk(1, 1, 16'h03FF, 2, 10'h081, 1, 0, 0, 1);  // ir_write ignored in EXEC
    vecs[5]  = mk(1, 0, 16'h0000, 3, 10'h081, 1, 0, 1, 1);
    vecs[6]  = mk(1, 0, 16'h0000, 0, 10'h081, 1, 0, 0, 2);
    vecs[7]  = mk(1, 1, 16'h0113, 1, 10'h113, 1, 0, 0, 2);  // ld
    vecs[8]  = mk(1, 0, 16'h0000, 2, 10'h113, 1, 0, 1, 2);
    vecs[9]  = mk(1, 0, 16'h0000, 0, 10'h113, 1, 0, 0, 3);  // no bubble
    vecs[10] = mk(1, 1, 16'h015C, 1, 10'h15C, 1, 0, 0, 3);  // st
    vecs[11] = mk(1, 0, 16'h0000, 2, 10'h15C, 1, 0, 1, 3);
    vecs[12] = mk(0, 0, 16'h0000, 0, 10'h15C, 0, 0, 0, 4);  // run falls at last step
    vecs[13] = mk(0, 0, 16'h0000, 0, 10'h15C, 0, 0, 0, 4);
    vecs[14] = mk(1, 0, 16'h0000, 0, 10'h15C, 1, 0, 0, 4);
    vecs[15] = mk(1, 0, 16'h02C0, 1, 10'h15C, 1, 0, 0, 4);  // held opcode reused
    vecs[16] = mk(0, 0, 16'h0000, 2, 10'h15C, 1, 0, 1, 4);
    vecs[17] = mk(0, 0, 16'h0000, 0, 10'h15C, 0, 0, 0, 5);
    vecs[18] = mk(1, 0, 16'h0000, 0, 10'h15C, 1, 0, 0, 5);
    vecs[19] = mk(1, 1, 16'h0081, 1, 10'h081, 1, 0, 0, 5);
    vecs[20] = mk(0, 0, 16'h0000, 2, 10'h081, 1, 0, 0, 5);  // run dropped mid-ALU
    vecs[21] = mk(0, 0, 16'h0000, 3, 10'h081, 1, 0, 1, 5);
    vecs[22] = mk(0, 0, 16'h0000, 0, 10'h081, 0, 0, 0, 6);
    vecs[23] = mk(1, 0, 16'h0000, 0, 10'h081, 1, 0, 0, 6);
    vecs[24] = mk(1, 1, 16'h0181, 1, 10'h181, 1, 0, 1, 6);  // mvnz
    vecs[25] = mk(1, 0, 16'h0000, 0, 10'h181, 1, 0, 0, 7);
    vecs[26] = mk(1, 1, 16'h02C0, 0, 10'h2C0, 0, 1, 0, 7);  // halt
    vecs[27] = mk(0, 0, 16'h0000, 0, 10'h2C0, 0, 1, 0, 7);
    vecs[28] = mk(1, 1, 16'h0048, 0, 10'h2C0, 0, 1, 0, 7);  // IR frozen in HALT

    reset_n      = 1'b0;
    bus.run      = 1'b0;
    bus.ir_write = 1'b0;
    bus.din      = 16'h0;
    repeat (2) @(posedge clock);
    #1;
    check_now("reset", mk(0, 0, 16'h0, 0, 10'h000, 0, 0, 0, 0));
    reset_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset out of HALT, then an undefined opcode also parks the core.
    pulse_reset_and_check("halt_reset");
    run_vec("undef_fetch", mk(1, 0, 16'h0000, 0, 10'h000, 1, 0, 0, 0));
    run_vec("undef_halt",  mk(1, 1, 16'h0380, 0, 10'h380, 0, 1, 0, 0));
    pulse_reset_and_check("undef_reset");

    // Reset mid-EXEC of st at counter 2 with a nonzero retired count.
    run_vec("mr_fetch0", mk(1, 0, 16'h0000, 0, 10'h000, 1, 0, 0, 0));
    run_vec("mr_mvi",    mk(1, 1, 16'h0048, 1, 10'h048, 1, 0, 1, 0));
    run_vec("mr_fetch1", mk(1, 0, 16'h0000, 0, 10'h048, 1, 0, 0, 1));
    run_vec("mr_st1",    mk(1, 1, 16'h015C, 1, 10'h15C, 1, 0, 0, 1));
    run_vec("mr_st2",    mk(0, 0, 16'h0000, 2, 10'h15C, 1, 0, 1, 1));
    pulse_reset_and_check("mid_exec_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
